// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one multi-cycle sqrt unit among N_REQ requesters.
// A winner's operand is latched and the unit is enabled until it reports done
// or the watchdog expires. The tagged result is then returned to the owner, and
// the enable is held low for a cool-down so the unit's sequencer restarts cleanly.
module sqrt_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TIMEOUT  = 255,
    parameter int COOL_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  sq_enable,
    output logic [31:0]           sq_d,
    input  logic [15:0]           sq_result,
    input  logic                  sq_done
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int COOL_W = $clog2(COOL_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, COOL} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   grant_idx;
    logic               found;
    logic [31:0]        grant_data;
    logic [7:0]         tmo_cnt;
    logic [COOL_W-1:0]  cool_cnt;
    logic [N_REQ-1:0]   ack_nxt;
    logic [N_REQ-1:0]   rsp_valid_nxt;
    logic               sq_enable_nxt;
    logic               busy_nxt;
    logic [31:0]        ops [N_REQ];

    // Split the flat operand bus into one word per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_ops
        assign ops[g] = req_data[32*g +: 32];
    end

    // Cyclic priority search starting at the round-robin pointer.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        idx        = 0;
        cand       = '0;
        found      = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = idx[PTR_W-1:0];
            if (!found && req[cand]) begin
                found      = 1'b1;
                grant_idx  = cand;
                grant_data = ops[cand];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: done wins over the watchdog when both land on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = BUSY;
            BUSY:    if (sq_done || tmo_cnt == 8'(TIMEOUT)) state_nxt = RESP;
            RESP:    state_nxt = COOL;
            COOL:    if (cool_cnt == COOL_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the coming transition.
    always_comb begin
        ack_nxt       = '0;
        rsp_valid_nxt = '0;
        if (state == IDLE && found) begin
            ack_nxt[grant_idx] = 1'b1;
        end
        if (state == BUSY && state_nxt == RESP) begin
            rsp_valid_nxt[owner] = 1'b1;
        end
        sq_enable_nxt = (state_nxt == BUSY);
        busy_nxt      = (state_nxt != IDLE);
    end

    // Output registers plus the operand, owner, pointer, watchdog and cool-down datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            tmo_cnt   <= '0;
            cool_cnt  <= '0;
            sq_d      <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ack       <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
            sq_enable <= 1'b0;
        end else begin
            ack       <= ack_nxt;
            rsp_valid <= rsp_valid_nxt;
            busy      <= busy_nxt;
            sq_enable <= sq_enable_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        sq_d    <= grant_data;
                        owner   <= grant_idx;
                        tmo_cnt <= '0;
                        ptr     <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                    end
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (sq_done) begin
                        rsp_data <= sq_result;
                        rsp_err  <= 1'b0;
                    end else if (tmo_cnt == 8'(TIMEOUT)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    cool_cnt <= COOL_W'(COOL_CYC);
                end
                COOL: begin
                    cool_cnt <= cool_cnt - COOL_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt unit and a response scoreboard.
module tb_sqrt_arbiter;

    localparam int N_REQ    = 4;
    localparam int TIMEOUT  = 255;
    localparam int COOL_CYC = 2;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    rsp_valid;
    logic [15:0]         rsp_data;
    logic                rsp_err;
    logic                busy;
    logic                sq_enable;
    logic [31:0]         sq_d;
    logic [15:0]         sq_result;
    logic                sq_done;

    logic [31:0] op_arr [N_REQ];
    bit          model_done;
    bit          spur_done;
    int          model_lat;
    int          en_cnt;

    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;
    int          en_hi;
    logic [3:0]  seen;
    logic [1:0]  cur;
    logic        rv_seen;

    sqrt_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .COOL_CYC(COOL_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .sq_enable (sq_enable),
        .sq_d      (sq_d),
        .sq_result (sq_result),
        .sq_done   (sq_done)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bus
        assign req_data[32*g +: 32] = op_arr[g];
    end

    // Square root of D in Q.10 fixed point: floor(sqrt(D * 2^20)).
    function automatic logic [15:0] sqrt_q10(input logic [31:0] d);
        logic [63:0] x;
        logic [63:0] r;
        logic [63:0] t;
        x = {12'd0, d, 20'd0};
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r[15:0];
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    assign sq_result = sqrt_q10(sq_d);
    assign sq_done   = model_done | spur_done;

    // Behavioural sqrt unit: raises done model_lat cycles after enable rises, never if model_lat is 0.
    always @(posedge clk) begin
        if (sq_enable) begin
            en_cnt     <= en_cnt + 1;
            model_done <= (model_lat != 0) && (en_cnt + 1 >= model_lat);
        end else begin
            en_cnt     <= 0;
            model_done <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] idx, input logic [31:0] operand, input logic level);
        op_arr[idx] = operand;
        req[idx]    = level;
    endtask

    task automatic push_exp(input logic [1:0] idx, input logic [15:0] data, input logic err);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int max_cyc, output int n, output logic [3:0] got);
        n   = 0;
        got = '0;
        while (n < max_cyc && got == 4'b0) begin
            @(negedge clk);
            n++;
            got = ack;
        end
    endtask

    task automatic compare_rsp(input string tag);
        exp_t e;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("[TB] FAIL %s_queued: observed response, expected none pending", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'(onehot(e.idx)));
            checkOutput({tag, "_data"}, 32'(rsp_data), 32'(e.data));
            checkOutput({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    task automatic check_rsp(input string tag, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc && rsp_valid == 4'b0) begin
            @(negedge clk);
            n++;
        end
        compare_rsp(tag);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_sq_enable"}, 32'(sq_enable), 32'd0);
        checkOutput({tag, "_sq_d"}, sq_d, 32'd0);
    endtask

    // Runaway guard in case a bounded wait is ever bypassed.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        req       = '0;
        spur_done = 1'b0;
        model_lat = 70;
        for (int i = 0; i < N_REQ; i++) op_arr[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] contention, all four requesting");
        model_lat = 5;
        for (int i = 0; i < N_REQ; i++) begin
            applyStimulus(2'(i), 32'(4 * (i + 1) * (i + 1)), 1'b1);
            push_exp(2'(i), sqrt_q10(32'(4 * (i + 1) * (i + 1))), 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            cur = 2'(k % 4);
            wait_ack(20, cyc, seen);
            checkOutput($sformatf("cont_ack%0d", k), 32'(seen), 32'(onehot(cur)));
            if (k > 0) checkOutput($sformatf("cont_gap%0d", k), cyc, 32'd4);
            applyStimulus(cur, op_arr[cur], 1'b0);
            check_rsp($sformatf("cont_rsp%0d", k), 40, cyc);
            if (k < 4) begin
                applyStimulus(cur, op_arr[cur], 1'b1);
                push_exp(cur, sqrt_q10(op_arr[cur]), 1'b0);
            end
        end
        repeat (3) @(negedge clk);
        checkOutput("cont_idle_busy", 32'(busy), 32'd0);

        $display("[TB] single request on requester 2");
        model_lat = 70;
        applyStimulus(2'd2, 32'h0000_0019, 1'b1);
        push_exp(2'd2, 16'h1400, 1'b0);
        wait_ack(10, cyc, seen);
        checkOutput("single_ack", 32'(seen), 32'b0100);
        checkOutput("single_ack_lat", cyc, 32'd1);
        checkOutput("single_en", 32'(sq_enable), 32'd1);
        checkOutput("single_sq_d", sq_d, 32'h0000_0019);
        checkOutput("single_busy", 32'(busy), 32'd1);
        applyStimulus(2'd2, 32'h0000_0019, 1'b0);
        en_hi = 1;
        cyc   = 0;
        while (rsp_valid == 4'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sq_enable) en_hi++;
        end
        checkOutput("single_en_cycles", en_hi, 32'd71);
        checkOutput("single_rsp_en", 32'(sq_enable), 32'd0);
        compare_rsp("single_rsp");
        for (int c = 0; c < COOL_CYC; c++) begin
            @(negedge clk);
            checkOutput($sformatf("single_cool_en%0d", c), 32'(sq_enable), 32'd0);
            checkOutput($sformatf("single_cool_busy%0d", c), 32'(busy), 32'd1);
        end
        @(negedge clk);
        checkOutput("single_idle_busy", 32'(busy), 32'd0);
        checkOutput("single_hold_data", 32'(rsp_data), 32'h1400);

        $display("[TB] watchdog timeout on requester 1");
        model_lat = 0;
        applyStimulus(2'd1, 32'h0000_0051, 1'b1);
        push_exp(2'd1, 16'h0000, 1'b1);
        wait_ack(10, cyc, seen);
        checkOutput("tmo_ack", 32'(seen), 32'b0010);
        applyStimulus(2'd1, 32'h0000_0051, 1'b0);
        check_rsp("tmo_rsp", 300, cyc);
        checkOutput("tmo_latency", cyc, 32'd256);
        for (int c = 0; c < COOL_CYC; c++) begin
            @(negedge clk);
            checkOutput($sformatf("tmo_cool_en%0d", c), 32'(sq_enable), 32'd0);
            checkOutput($sformatf("tmo_cool_busy%0d", c), 32'(busy), 32'd1);
        end
        @(negedge clk);
        checkOutput("tmo_idle_busy", 32'(busy), 32'd0);

        $display("[TB] done on the final watchdog cycle");
        model_lat = 255;
        applyStimulus(2'd0, 32'h0000_0031, 1'b1);
        push_exp(2'd0, 16'h1C00, 1'b0);
        wait_ack(10, cyc, seen);
        checkOutput("bound_ack", 32'(seen), 32'b0001);
        applyStimulus(2'd0, 32'h0000_0031, 1'b0);
        check_rsp("bound_rsp", 300, cyc);
        checkOutput("bound_latency", cyc, 32'd256);
        repeat (3) @(negedge clk);

        $display("[TB] spurious done in idle");
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        checkOutput("spur_idle_busy", 32'(busy), 32'd0);
        checkOutput("spur_idle_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("spur_idle_en", 32'(sq_enable), 32'd0);
        @(negedge clk);
        checkOutput("spur_idle_rsp2", 32'(rsp_valid), 32'd0);

        $display("[TB] spurious done in cool-down");
        model_lat = 3;
        applyStimulus(2'd3, 32'h0000_0040, 1'b1);
        push_exp(2'd3, 16'h2000, 1'b0);
        wait_ack(10, cyc, seen);
        checkOutput("spur_cool_ack", 32'(seen), 32'b1000);
        applyStimulus(2'd3, 32'h0000_0040, 1'b0);
        check_rsp("spur_cool_rsp", 40, cyc);
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        checkOutput("spur_cool_rsp2", 32'(rsp_valid), 32'd0);
        checkOutput("spur_cool_busy", 32'(busy), 32'd1);
        checkOutput("spur_cool_en", 32'(sq_enable), 32'd0);
        @(negedge clk);
        checkOutput("spur_cool_idle", 32'(busy), 32'd0);

        $display("[TB] reset in the middle of a transaction");
        model_lat = 0;
        applyStimulus(2'd2, 32'h0000_0019, 1'b1);
        wait_ack(10, cyc, seen);
        checkOutput("rst_ack", 32'(seen), 32'b0100);
        applyStimulus(2'd2, 32'h0000_0019, 1'b0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst     = 1'b0;
        rv_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            rv_seen = rv_seen | (rsp_valid != 4'b0);
        end
        checkOutput("midrst_no_rsp", 32'(rv_seen), 32'd0);

        model_lat = 4;
        applyStimulus(2'd3, 32'h0000_0090, 1'b1);
        push_exp(2'd3, 16'h3000, 1'b0);
        wait_ack(10, cyc, seen);
        checkOutput("post_rst_ack3", 32'(seen), 32'b1000);
        applyStimulus(2'd3, 32'h0000_0090, 1'b0);
        check_rsp("post_rst_rsp3", 40, cyc);
        repeat (3) @(negedge clk);

        applyStimulus(2'd1, 32'h0000_0010, 1'b1);
        applyStimulus(2'd3, 32'h0000_0024, 1'b1);
        push_exp(2'd1, 16'h1000, 1'b0);
        wait_ack(10, cyc, seen);
        checkOutput("ptr0_ack1", 32'(seen), 32'b0010);
        applyStimulus(2'd1, 32'h0000_0010, 1'b0);
        check_rsp("ptr0_rsp1", 40, cyc);
        push_exp(2'd3, 16'h1800, 1'b0);
        wait_ack(10, cyc, seen);
        checkOutput("ptr0_ack3", 32'(seen), 32'b1000);
        checkOutput("ptr0_gap3", cyc, 32'd4);
        applyStimulus(2'd3, 32'h0000_0024, 1'b0);
        check_rsp("ptr0_rsp3", 40, cyc);
        repeat (3) @(negedge clk);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
